gcd_unit: RTL

GCD_UNIT -- requirements
Module: gcd_unit

---
 rtl/gcd_pkg.sv | 13 +
 rtl/gcd_ctrl.sv | 63 ++++++
 rtl/gcd_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD unit: control-state encoding and algorithm select values.
package gcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } gcd_state_e;

  localparam logic GCD_MODE_EUCLID = 1'b0;
  localparam logic GCD_MODE_BINARY = 1'b1;

endpackage

// File: rtl/gcd_ctrl.sv
// Control FSM for the GCD unit: sequences idle/compute/done and issues load/step strobes.
// Handshake: a start is taken only while ready_o=1; a result is held with done_o=1 until ack_i=1.
module gcd_ctrl
  import gcd_pkg::*;
(
  input  logic       clk_i,
  input  logic       nreset_i,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       ack_i,
  input  logic       finish_i,
  output gcd_state_e state_o,
  output logic       ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       load_o,
  output logic       step_o
);

  gcd_state_e state_q, state_d;

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    load_o  = 1'b0;
    step_o  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_COMPUTE;
          load_o  = 1'b1;
        end
      end
      S_COMPUTE: begin
        step_o = 1'b1;
        if (finish_i) state_d = S_DONE;
      end
      S_DONE: begin
        if (ack_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort wins over start, ack and completion, and suppresses all datapath updates.
    if (abort_i) begin
      state_d = S_IDLE;
      load_o  = 1'b0;
      step_o  = 1'b0;
    end
  end

  assign state_o = state_q;
  assign ready_o = (state_q == S_IDLE);
  assign busy_o  = (state_q == S_COMPUTE);
  assign done_o  = (state_q == S_DONE);

endmodule

// File: rtl/gcd_unit.sv
// Iterative GCD engine: subtractive Euclid or binary (Stein) selected per operation.
// One algorithm action per compute cycle; result and cycle count held until the next start.
module gcd_unit
  import gcd_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             nreset_i,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             abort_i,
  input  logic             ack_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH:0]   cycles_o
);

  localparam int KW = $clog2(WIDTH) + 1;
  localparam int CW = WIDTH + 1;

  gcd_state_e       state;
  logic             load, step, finish;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CW-1:0]    cnt_q, cnt_d, cycles_q, cycles_d, cnt_inc;
  logic             mode_q, mode_d, binary;

  gcd_ctrl u_ctrl (
    .clk_i    (clk_i),
    .nreset_i (nreset_i),
    .start_i  (start_i),
    .abort_i  (abort_i),
    .ack_i    (ack_i),
    .finish_i (finish),
    .state_o  (state),
    .ready_o  (ready_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .load_o   (load),
    .step_o   (step)
  );

  assign finish  = (a_q == '0) || (b_q == '0);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
  assign binary  = (mode_q == GCD_MODE_BINARY);

  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    result_d = result_q;
    cycles_d = cycles_q;
    if (load) begin
      a_d    = a_i;
      b_d    = b_i;
      mode_d = mode_i;
      k_d    = '0;
      cnt_d  = '0;
    end else if (step) begin
      cnt_d = cnt_inc;
      // k only grows when both operands shared a factor of two, so the shift cannot overflow.
      if (a_q == '0) begin
        result_d = b_q << k_q;
        cycles_d = cnt_inc;
      end else if (b_q == '0) begin
        result_d = a_q << k_q;
        cycles_d = cnt_inc;
      end else if (binary && !a_q[0] && !b_q[0]) begin
        a_d = a_q >> 1;
        b_d = b_q >> 1;
        k_d = k_q + KW'(1);
      end else if (binary && !a_q[0]) begin
        a_d = a_q >> 1;
      end else if (binary && !b_q[0]) begin
        b_d = b_q >> 1;
      end else if (a_q >= b_q) begin
        a_d = a_q - b_q;
      end else begin
        b_d = b_q - a_q;
      end
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      a_q      <= '0;
      b_q      <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      mode_q   <= GCD_MODE_EUCLID;
      result_q <= '0;
      cycles_q <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      cycles_q <= cycles_d;
    end
  end

  assign result_o = result_q;
  assign cycles_o = cycles_q;

endmodule
